// File: rtl/rename_pkg.sv
// Shared types and sizing for the rename issue controller.
package rename_pkg;

    localparam int NUM_ARCH         = 32;
    localparam int NUM_PHYS         = 64;
    localparam int ARCH_W           = $clog2(NUM_ARCH);
    localparam int PHYS_W           = $clog2(NUM_PHYS);
    localparam int CNT_W            = PHYS_W + 1;
    localparam int FLUSH_CYCLES_DEF = 3;

    // One decoded instruction as held in the skid buffer.
    typedef struct packed {
        logic [ARCH_W-1:0] rd;
        logic [ARCH_W-1:0] rs1;
        logic [ARCH_W-1:0] rs2;
        logic              wr_en;
    } dec_instr_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } issue_state_e;

    // Writes to x0 never allocate a physical register, so they need no credit.
    function automatic logic needs_credit(input dec_instr_t instr);
        return instr.wr_en && (instr.rd != '0);
    endfunction

endpackage

// File: rtl/rename_skid_buf.sv
// Two-entry FIFO of decoded instructions between decode and rename issue.
module rename_skid_buf
    import rename_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic       clear_i,
    input  dec_instr_t din_i,
    output dec_instr_t dout_o,
    output logic       full_o,
    output logic       empty_o,
    output logic [1:0] count_o
);

    dec_instr_t mem_q [2];
    logic       rd_ptr_q;
    logic       wr_ptr_q;
    logic [1:0] count_q;

    // Pointer and occupancy bookkeeping; clear empties the buffer in one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (clear_i) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) wr_ptr_q <= ~wr_ptr_q;
            if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    // Entry storage; contents are only observed through a valid count.
    // NOTE: storage is deliberately not reset -- occupancy is tracked by count_q, so stale data is never read.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/rename_issue_ctrl.sv
// Rename issue controller: decode skid buffer, physical-register credit
// tracking, retire forwarding and pipeline flush sequencing.
// Optional macro RENAME_ISSUE_STATS_EN adds the stall_cycles counter output.
module rename_issue_ctrl
    import rename_pkg::*;
#(
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              dec_valid,
    output logic              dec_ready,
    input  logic [ARCH_W-1:0] dec_rd,
    input  logic [ARCH_W-1:0] dec_rs1,
    input  logic [ARCH_W-1:0] dec_rs2,
    input  logic              dec_wr_en,
    output logic              issue_valid,
    output logic [ARCH_W-1:0] rd,
    output logic [ARCH_W-1:0] rs1,
    output logic [ARCH_W-1:0] rs2,
    input  logic              rob_retire_valid,
    input  logic [PHYS_W-1:0] rob_retire_phys_reg,
    output logic              retire_valid,
    output logic [PHYS_W-1:0] retire_phys_reg,
    input  logic              flush,
    input  logic [CNT_W-1:0]  flush_free_count,
    output logic [CNT_W-1:0]  free_count,
    output logic              credit_err
`ifdef RENAME_ISSUE_STATS_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);

    localparam int              FC_W       = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int              SUM_W      = CNT_W + 1;
    localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(NUM_PHYS - NUM_ARCH);

    issue_state_e      state_q, state_d;
    logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic              dec_ready_q, dec_ready_d;
    logic              issue_valid_q;
    dec_instr_t        issued_q, issued_d;
    logic              retire_valid_q;
    logic [PHYS_W-1:0] retire_phys_q;
    logic [CNT_W-1:0]  free_count_q, free_count_d;
    logic              credit_err_q, credit_err_d;
    logic [SUM_W-1:0]  credit_base, credit_sum;

    dec_instr_t        dec_instr, head;
    logic              push, pop, full, empty;
    logic [1:0]        count, occ_next;
    logic              head_needs, head_blocked;

    assign dec_instr    = '{rd: dec_rd, rs1: dec_rs1, rs2: dec_rs2, wr_en: dec_wr_en};
    assign push         = dec_valid && dec_ready_q && !flush && !full;
    assign head_needs   = needs_credit(head);
    assign head_blocked = !empty && head_needs && (free_count_q == '0);

    rename_skid_buf u_skid_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (flush),
        .din_i   (dec_instr),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    // Issue FSM: pop the head when it is issuable, park in STALL when it lacks a credit.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        pop         = 1'b0;
        if (flush) begin
            state_d     = FLUSH;
            flush_cnt_d = FC_W'(FLUSH_CYCLES - 1);
        end else begin
            unique case (state_q)
                RUN, STALL: begin
                    pop     = !empty && !head_blocked;
                    state_d = head_blocked ? STALL : RUN;
                end
                FLUSH: begin
                    if (flush_cnt_q == '0) state_d = RUN;
                    else                   flush_cnt_d = flush_cnt_q - 1'b1;
                end
                default: state_d = RUN;
            endcase
        end
    end

    // Credit update: issue consumption and retire return land on the same edge;
    // a retire that would exceed the architectural-reset level saturates and flags.
    always_comb begin
        credit_err_d = credit_err_q;
        credit_base  = flush ? {1'b0, flush_free_count}
                             : {1'b0, free_count_q} - SUM_W'(pop && head_needs);
        credit_sum   = credit_base + SUM_W'(rob_retire_valid);
        free_count_d = credit_sum[CNT_W-1:0];
        if (rob_retire_valid && (credit_sum > {1'b0, CREDIT_MAX})) begin
            free_count_d = CREDIT_MAX;
            credit_err_d = 1'b1;
        end
    end

    // Ready is registered from next-cycle occupancy so back-to-back transfers keep flowing.
    always_comb begin
        occ_next    = flush ? 2'd0 : (count + {1'b0, push} - {1'b0, pop});
        dec_ready_d = (occ_next != 2'd2) && (state_d != FLUSH);
        issued_d    = pop ? head : issued_q;
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= RUN;
            flush_cnt_q    <= '0;
            dec_ready_q    <= 1'b0;
            issue_valid_q  <= 1'b0;
            issued_q       <= '0;
            retire_valid_q <= 1'b0;
            retire_phys_q  <= '0;
            free_count_q   <= CREDIT_MAX;
            credit_err_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            flush_cnt_q    <= flush_cnt_d;
            dec_ready_q    <= dec_ready_d;
            issue_valid_q  <= pop;
            issued_q       <= issued_d;
            retire_valid_q <= rob_retire_valid;
            retire_phys_q  <= rob_retire_phys_reg;
            free_count_q   <= free_count_d;
            credit_err_q   <= credit_err_d;
        end
    end

`ifdef RENAME_ISSUE_STATS_EN
    logic [31:0] stall_cnt_q;

    // Saturating count of cycles spent waiting for a credit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                                    stall_cnt_q <= '0;
        else if (state_q == STALL && stall_cnt_q != '1)  stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign stall_cycles = stall_cnt_q;
`endif

    assign dec_ready       = dec_ready_q;
    assign issue_valid     = issue_valid_q;
    assign rd              = issued_q.rd;
    assign rs1             = issued_q.rs1;
    assign rs2             = issued_q.rs2;
    assign retire_valid    = retire_valid_q;
    assign retire_phys_reg = retire_phys_q;
    assign free_count      = free_count_q;
    assign credit_err      = credit_err_q;

endmodule

// File: tb/tb_rename_issue_ctrl.sv
// Self-checking bench for rename_issue_ctrl: directed scenarios followed by
// randomized traffic, checked by a queue-based reference model and monitor.
module tb_rename_issue_ctrl;
    import rename_pkg::*;

    localparam int FC   = 3;
    localparam int MAXC = NUM_PHYS - NUM_ARCH;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              dec_valid = 1'b0;
    logic              dec_ready;
    logic [ARCH_W-1:0] dec_rd = '0, dec_rs1 = '0, dec_rs2 = '0;
    logic              dec_wr_en = 1'b0;
    logic              issue_valid;
    logic [ARCH_W-1:0] rd, rs1, rs2;
    logic              rob_retire_valid = 1'b0;
    logic [PHYS_W-1:0] rob_retire_phys_reg = '0;
    logic              retire_valid;
    logic [PHYS_W-1:0] retire_phys_reg;
    logic              flush = 1'b0;
    logic [CNT_W-1:0]  flush_free_count = '0;
    logic [CNT_W-1:0]  free_count;
    logic              credit_err;
`ifdef RENAME_ISSUE_STATS_EN
    logic [31:0]       stall_cycles;
`endif

    rename_issue_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .dec_valid           (dec_valid),
        .dec_ready           (dec_ready),
        .dec_rd              (dec_rd),
        .dec_rs1             (dec_rs1),
        .dec_rs2             (dec_rs2),
        .dec_wr_en           (dec_wr_en),
        .issue_valid         (issue_valid),
        .rd                  (rd),
        .rs1                 (rs1),
        .rs2                 (rs2),
        .rob_retire_valid    (rob_retire_valid),
        .rob_retire_phys_reg (rob_retire_phys_reg),
        .retire_valid        (retire_valid),
        .retire_phys_reg     (retire_phys_reg),
        .flush               (flush),
        .flush_free_count    (flush_free_count),
        .free_count          (free_count),
        .credit_err          (credit_err)
`ifdef RENAME_ISSUE_STATS_EN
        ,
        .stall_cycles        (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Buffer is a queue of accepted instructions, credits a plain integer,
    // flush a countdown of blocked cycles.
    dec_instr_t        m_buf[$];
    dec_instr_t        exp_iss[$];
    logic [PHYS_W-1:0] exp_ret[$];
    int                m_cred = MAXC;
    int                m_flush_left = 0;
    bit                m_err = 0, m_ready = 0, m_iss = 0, m_ret = 0;
    dec_instr_t        m_last = '0;

    initial forever begin
        bit         iss;
        bit         need;
        dec_instr_t h;
        dec_instr_t n;
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_buf.delete(); exp_iss.delete(); exp_ret.delete();
            m_cred = MAXC; m_flush_left = 0; m_err = 0; m_ready = 0;
            m_iss = 0; m_ret = 0; m_last = '0;
        end else begin
            iss = 0;
            if (flush) begin
                m_buf.delete();
                m_cred = int'(flush_free_count);
                m_flush_left = FC;
            end else if (m_flush_left > 0) begin
                m_flush_left--;
            end else begin
                if (m_buf.size() > 0) begin
                    h = m_buf[0];
                    need = h.wr_en && (h.rd != 0);
                    if (!need || m_cred > 0) begin
                        iss = 1;
                        void'(m_buf.pop_front());
                        exp_iss.push_back(h);
                        m_last = h;
                        if (need) m_cred--;
                    end
                end
                if (dec_valid && m_ready) begin
                    n.rd = dec_rd; n.rs1 = dec_rs1; n.rs2 = dec_rs2; n.wr_en = dec_wr_en;
                    m_buf.push_back(n);
                end
            end
            if (rob_retire_valid) begin
                exp_ret.push_back(rob_retire_phys_reg);
                if (m_cred + 1 > MAXC) begin
                    m_cred = MAXC;
                    m_err = 1;
                end else begin
                    m_cred++;
                end
            end
            m_iss   = iss;
            m_ret   = rob_retire_valid;
            m_ready = (m_buf.size() < 2) && (m_flush_left == 0);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial forever begin
        dec_instr_t        e;
        logic [PHYS_W-1:0] pr;
        @(negedge clk);
        check("dec_ready",   64'(dec_ready),   64'(m_ready));
        check("free_count",  64'(free_count),  64'(m_cred));
        check("credit_err",  64'(credit_err),  64'(m_err));
        check("issue_valid", 64'(issue_valid), 64'(m_iss));
        if (issue_valid) begin
            check("issue_pending", 64'(exp_iss.size() > 0), 64'(1));
            if (exp_iss.size() > 0) begin
                e = exp_iss.pop_front();
                check("issue_fields", 64'({rd, rs1, rs2}), 64'({e.rd, e.rs1, e.rs2}));
            end
        end
        check("held_fields", 64'({rd, rs1, rs2}), 64'({m_last.rd, m_last.rs1, m_last.rs2}));
        check("retire_valid", 64'(retire_valid), 64'(m_ret));
        if (retire_valid) begin
            check("retire_pending", 64'(exp_ret.size() > 0), 64'(1));
            if (exp_ret.size() > 0) begin
                pr = exp_ret.pop_front();
                check("retire_phys_reg", 64'(retire_phys_reg), 64'(pr));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int r, input int s1, input int s2, input bit w);
        int   waited;
        logic acc;
        waited = 0;
        dec_valid = 1'b1;
        dec_rd = ARCH_W'(r); dec_rs1 = ARCH_W'(s1); dec_rs2 = ARCH_W'(s2); dec_wr_en = w;
        do begin
            @(negedge clk);
            acc = dec_ready;
            tick();
            waited++;
        end while (!acc && waited < 200);
        check("send_accept", 64'(acc), 64'(1));
        dec_valid = 1'b0;
    endtask

    task automatic retire_pulse(input int phys);
        rob_retire_valid = 1'b1;
        rob_retire_phys_reg = PHYS_W'(phys);
        tick();
        rob_retire_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_dec_ready"},   64'(dec_ready),   64'(0));
        check({tag, "_issue_valid"}, 64'(issue_valid), 64'(0));
        check({tag, "_retire"},      64'(retire_valid), 64'(0));
        check({tag, "_fields"},      64'({rd, rs1, rs2, retire_phys_reg}), 64'(0));
        check({tag, "_free_count"},  64'(free_count),  64'(MAXC));
        check({tag, "_credit_err"},  64'(credit_err),  64'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic acc;
        repeat (3) tick();
        check_reset_values("reset");
        reset_n = 1'b1;
        check("ready_low_at_release", 64'(dec_ready), 64'(0));
        tick();
        check("ready_after_reset", 64'(dec_ready), 64'(1));

        // Three back-to-back writes.
        send(1, 4, 5, 1'b1);
        check("first_not_yet_issued", 64'(issue_valid), 64'(0));
        send(2, 6, 7, 1'b1);
        check("first_issue", 64'({issue_valid, rd}), 64'({1'b1, 5'd1}));
        send(3, 8, 9, 1'b1);
        check("second_issue", 64'({issue_valid, rd}), 64'({1'b1, 5'd2}));
        tick();
        check("third_issue", 64'({issue_valid, rd}), 64'({1'b1, 5'd3}));
        tick();
        check("credits_29", 64'(free_count), 64'(29));

        // Drain all credits.
        for (int i = 0; i < 29; i++) send((i % 31) + 1, i % 32, (i + 3) % 32, 1'b1);
        repeat (3) tick();
        check("credits_0", 64'(free_count), 64'(0));

        // x0 write and non-writing instruction issue without credits.
        send(0, 1, 2, 1'b1);
        send(7, 3, 4, 1'b0);
        repeat (2) tick();
        check("x0_nowr_credits", 64'(free_count), 64'(0));

        // Credit-starved write stalls; buffer fills.
        send(5, 10, 11, 1'b1);
        send(6, 12, 13, 1'b1);
        repeat (4) tick();
        check("stall_no_issue", 64'(issue_valid), 64'(0));
        check("stall_full_ready", 64'(dec_ready), 64'(0));
        retire_pulse(40);
        check("retire40_fwd", 64'({retire_valid, retire_phys_reg}), 64'({1'b1, 6'd40}));
        check("retire40_no_issue_yet", 64'(issue_valid), 64'(0));
        tick();
        check("stall_release_issue", 64'({issue_valid, rd}), 64'({1'b1, 5'd5}));
        retire_pulse(41);
        tick();
        check("second_release_issue", 64'({issue_valid, rd}), 64'({1'b1, 5'd6}));
        retire_pulse(50);
        repeat (2) tick();

        // Issue with a same-cycle retire.
        send(9, 1, 1, 1'b1);
        rob_retire_valid = 1'b1; rob_retire_phys_reg = 6'd2;
        tick();
        rob_retire_valid = 1'b0;
        check("same_edge_issue", 64'({issue_valid, rd}), 64'({1'b1, 5'd9}));
        check("same_edge_credits", 64'(free_count), 64'(1));
        check("same_edge_retire", 64'({retire_valid, retire_phys_reg}), 64'({1'b1, 6'd2}));

        // Flush while two entries wait.
        send(10, 0, 0, 1'b1);
        send(11, 0, 0, 1'b1);
        send(12, 0, 0, 1'b1);
        tick();
        check("pre_flush_full", 64'(dec_ready), 64'(0));
        flush = 1'b1; flush_free_count = 7'd20;
        tick();
        flush = 1'b0;
        check("flush_load", 64'(free_count), 64'(20));
        for (int i = 0; i < FC; i++) begin
            check("flush_ready_low", 64'({dec_ready, issue_valid}), 64'(0));
            tick();
        end
        check("flush_ready_back", 64'(dec_ready), 64'(1));
        repeat (3) tick();

        // Overflow: return credits up to the limit and beyond.
        rob_retire_valid = 1'b1;
        for (int i = 0; i < 13; i++) begin
            rob_retire_phys_reg = PHYS_W'(20 + i);
            tick();
        end
        rob_retire_valid = 1'b0;
        check("overflow_sat", 64'(free_count), 64'(MAXC));
        check("overflow_err", 64'(credit_err), 64'(1));
        send(3, 2, 1, 1'b1);
        tick();
        check("post_err_issue", 64'({issue_valid, free_count, credit_err}), 64'({1'b1, 7'd31, 1'b1}));

        // Asynchronous reset mid-cycle.
        #1 reset_n = 1'b0;
        #1 check_reset_values("async_reset");
        tick();
        reset_n = 1'b1;
        tick();

        // Randomized traffic.
        acc = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!dec_valid || acc) begin
                dec_valid = ($urandom_range(0, 9) < 7);
                dec_rd    = ($urandom_range(0, 9) == 0) ? '0 : ARCH_W'($urandom);
                dec_rs1   = ARCH_W'($urandom);
                dec_rs2   = ARCH_W'($urandom);
                dec_wr_en = ($urandom_range(0, 9) < 8);
            end
            rob_retire_valid    = ($urandom_range(0, 99) < 35);
            rob_retire_phys_reg = PHYS_W'($urandom);
            flush               = ($urandom_range(0, 99) < 2);
            flush_free_count    = CNT_W'($urandom_range(0, MAXC));
            @(negedge clk);
            acc = dec_valid && dec_ready;
            tick();
        end
        dec_valid = 1'b0; rob_retire_valid = 1'b0; flush = 1'b0;
        repeat (10) tick();
        check("issue_queue_drained", 64'(exp_iss.size()), 64'(0));
        check("retire_queue_drained", 64'(exp_ret.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
